// File: rtl/axis_seq_checker.sv
// AXI-Stream sink that checks incrementing-counter packets.
// Expected packet: LENGTH beats carrying data 0..LENGTH-1, with tlast on the
// final beat only. The checker first hunts for a tlast to align, then checks
// every accepted beat and keeps saturating status counters.
//
// state | meaning
// HUNT  | not aligned; waiting for an accepted tlast beat to sync on
// CHECK | aligned; every accepted beat is compared with the expected pattern
module axis_seq_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int LENGTH     = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  stall_en,
  input  logic                  clear,
  output logic                  locked,
  output logic                  error_sticky,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  good_pkt_count,
  output logic [CNT_WIDTH-1:0]  data_err_count,
  output logic [CNT_WIDTH-1:0]  last_err_count
);

  localparam int IDX_W = $clog2(LENGTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

  typedef enum logic {HUNT, CHECK} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             clean_q, clean_d;
  logic             rdy_q;
  logic             accept;
  logic             data_err, last_err;
  logic             inc_pkt, inc_good, inc_derr, inc_lerr, set_err;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    if (en && (v != {CNT_WIDTH{1'b1}})) return v + CNT_WIDTH'(1);
    return v;
  endfunction

  assign accept   = s_tvalid & rdy_q;
  assign data_err = (s_tdata != DATA_WIDTH'(idx_q));
  assign last_err = (s_tlast != (idx_q == LAST_IDX));
  assign s_tready = rdy_q;
  assign locked   = (state_q == CHECK);

  // Ready generator: free-running, optionally toggling to throttle upstream.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdy_q <= 1'b0;
    else       rdy_q <= stall_en ? ~rdy_q : 1'b1;
  end

  // FSM state, beat index and clean-packet flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= HUNT;
      idx_q   <= '0;
      clean_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      clean_q <= clean_d;
    end
  end

  // Next-state logic and per-beat counting events.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clean_d  = clean_q;
    inc_pkt  = 1'b0;
    inc_good = 1'b0;
    inc_derr = 1'b0;
    inc_lerr = 1'b0;
    set_err  = 1'b0;
    if (accept) begin
      case (state_q)
        HUNT: begin
          if (s_tlast) begin
            state_d = CHECK;
            idx_d   = '0;
            clean_d = 1'b1;
          end
        end
        CHECK: begin
          if (data_err || last_err) begin
            inc_derr = data_err;
            inc_lerr = last_err;
            set_err  = 1'b1;
            idx_d    = '0;
            if (s_tlast) begin
              // A tlast still marks a packet boundary, so resync right away.
              state_d = CHECK;
              clean_d = 1'b1;
              inc_pkt = 1'b1;
            end else begin
              state_d = HUNT;
              clean_d = 1'b0;
            end
          end else if (s_tlast) begin
            inc_pkt  = 1'b1;
            inc_good = clean_q;
            idx_d    = '0;
            clean_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Status counters and sticky error flag; clear takes priority over events.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_count      <= '0;
      good_pkt_count <= '0;
      data_err_count <= '0;
      last_err_count <= '0;
      error_sticky   <= 1'b0;
    end else if (clear) begin
      pkt_count      <= '0;
      good_pkt_count <= '0;
      data_err_count <= '0;
      last_err_count <= '0;
      error_sticky   <= 1'b0;
    end else begin
      pkt_count      <= sat_inc(pkt_count, inc_pkt);
      good_pkt_count <= sat_inc(good_pkt_count, inc_good);
      data_err_count <= sat_inc(data_err_count, inc_derr);
      last_err_count <= sat_inc(last_err_count, inc_lerr);
      if (set_err) error_sticky <= 1'b1;
    end
  end

endmodule

// File: doc/axis_seq_checker.md
Name: axis_seq_checker

Overview:
- AXI-Stream sink that sits directly downstream of the incrementing-counter stream source.
- Accepts beats and checks each packet against the expected pattern: LENGTH beats, data 0..LENGTH-1, tlast on the last beat only.
- Reports lock status, packet counts and error counts so the MicroBlaze (or an ILA) can confirm the source/FIFO path is clean.
- Optional throttle exercises upstream backpressure.

Parameters:
- DATA_WIDTH, 32, width of s_tdata.
- LENGTH, 32, expected beats per packet; must be >= 2.
- CNT_WIDTH, 16, width of each status counter; counters saturate at all-ones.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- s_tdata  input  DATA_WIDTH  stream data.
- s_tlast  input  1  end-of-packet marker.
- s_tvalid  input  1  upstream beat valid.
- s_tready  output  1  checker ready; registered.
- stall_en  input  1  1 = throttle s_tready to alternate cycles.
- clear  input  1  synchronous clear of counters and sticky flag.
- locked  output  1  1 while in CHECK state.
- error_sticky  output  1  set on any data/last error, held until clear or reset.
- pkt_count  output  CNT_WIDTH  packets completed in CHECK (tlast beats accepted).
- good_pkt_count  output  CNT_WIDTH  completed packets with zero errors.
- data_err_count  output  CNT_WIDTH  beats with wrong data.
- last_err_count  output  CNT_WIDTH  beats with tlast in the wrong position.

Behaviour:
- Reset (async, rstn=0):
  - state=HUNT, idx=0, s_tready=0, locked=0, error_sticky=0, all counters 0, pkt_clean=1.
  - Reset asserted mid-packet discards progress; the checker always restarts in HUNT.
- Handshake:
  - A beat is accepted iff s_tvalid & s_tready on a rising edge.
  - The checker never inspects unaccepted beats.
- s_tready:
  - Register rdy_q; each cycle rdy_q <= stall_en ? ~rdy_q : 1.
  - First cycle after reset release: s_tready=0, then 1.
  - With stall_en=1 the pattern is 1,0,1,0...
  - s_tready does not depend on s_tvalid.
- HUNT:
  - locked=0.
  - Accepted beat with s_tlast=1 -> idx<=0, pkt_clean<=1, state<=CHECK.
  - Beats in HUNT are not counted and raise no errors.
- CHECK (locked=1), on each accepted beat:
  - data_err = (s_tdata != zero-extended idx).
  - last_err = (s_tlast != (idx==LENGTH-1)).
  - If data_err or last_err:
    - increment the respective counter(s); both may increment on the same beat.
    - set error_sticky.
    - pkt_clean<=0.
    - state<=HUNT, idx<=0.
    - If that beat also had s_tlast=1, go to CHECK instead (immediate resync; next beat expects 0), and still count pkt_count (not good).
  - Else if s_tlast=1: pkt_count++, good_pkt_count++ (if pkt_clean), idx<=0, pkt_clean<=1.
  - Else idx<=idx+1.
- Width/arith:
  - idx width = clog2(LENGTH).
  - Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- clear:
  - Zeroes all four counters and error_sticky next edge.
  - Does not change state, idx or s_tready.
  - If clear coincides with a counting event, clear wins (event dropped).
  - If clear coincides with an error, error_sticky ends 0.
- Outputs are all registered; status reflects an accepted beat one cycle after the accepting edge.

Test Plan:
- Reset then stall_en=0; drive 3 clean packets (LENGTH=32, data 0..31, tlast on 31) -> after 1st tlast (HUNT sync) locked=1; after remaining 2 packets pkt_count=2, good_pkt_count=2, all err counts 0, error_sticky=0.
- Locked; corrupt beat 5 of a packet (data 0x55) -> data_err_count=1, error_sticky=1, locked=0 next cycle; resync on that packet's tlast; next clean packet -> locked=1, good_pkt_count+1.
- Locked; assert tlast on beat 10 (data correct) -> last_err_count=1, pkt_count+1, good_pkt_count unchanged, locked stays 1, next packet 0..31 clean -> good_pkt_count+1.
- stall_en=1 with s_tvalid held 1 for 64 cycles -> s_tready alternates 1/0, exactly 32 beats accepted, one packet counted, no errors.
- Pulse clear in the same cycle as a data error -> all counters 0, error_sticky=0, state=HUNT; then CNT_WIDTH=4, drive 20 clean packets -> pkt_count saturates at 15.
- Assert rstn=0 asynchronously mid-packet (between edges) -> outputs reset immediately, s_tready=0; after release, checker hunts and relocks on next tlast.
